key_autotype: RTL
=================

Name: key_autotype

Overview:
- Scheduler for the shared key-event port of the CPC keyboard matrix (key_strobe/key_pressed/key_code).
- Merges live PS/2 key events with an auto-type request stream, e.g. injecting RUN" after disk mount.
- Emits at most one event per clk, holds each auto-typed key for a tick-timed interval, and gives live events priority.
- Sits between the PS/2 decoder / loader control and the keyboard-matrix input block.

Parameters:
- HOLD_TICKS, 3: tick pulses an auto-typed key stays pressed; legal range 1..15.
- GAP_TICKS, 2: tick pulses of idle time after each auto-typed key's release; legal range 1..15.
- SHIFT_CODE, 8'h12: key code used for auto-shift (LShift).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick  in  1  one-clk timing pulse, frame rate (~50 Hz)
- live_strobe  in  1  live key event valid, one clk
- live_pressed  in  1  live event press(1)/release(0)
- live_code  in  8  live event key code
- at_valid  in  1  auto-type request valid
- at_code  in  8  key code to type
- at_shift  in  1  wrap the key in SHIFT_CODE press/release
- at_ready  out  1  request accepted when at_valid & at_ready
- at_abort  in  1  one-clk pulse; cancels the current auto-type key
- at_busy  out  1  sequence in progress (state != IDLE)
- out_strobe  out  1  merged event valid, one clk
- out_pressed  out  1  merged press/release
- out_code  out  8  merged key code

Behaviour:
- Reset values: all outputs 0 except at_ready=1. State=IDLE. Latched code/shift and tick counter cleared.
- Live path:
  - live_strobe registers to out_* one clk later; latency is exactly 1.
  - Live events are never dropped or reordered.
- Auto-type states: IDLE, SH_DN, K_DN, HOLD, K_UP, SH_UP, GAP.
- IDLE:
  - at_ready=1.
  - On at_valid, latch at_code/at_shift and set at_ready=0 the next clk.
  - Go to SH_DN if at_shift, else K_DN.
- Emit states (SH_DN, K_DN, K_UP, SH_UP) each emit one event:
  - SH_DN: SHIFT_CODE, pressed=1.
  - K_DN: code, pressed=1.
  - K_UP: code, pressed=0.
  - SH_UP: SHIFT_CODE, pressed=0.
  - An emit state whose live_strobe input is 1 in the same clk stalls and retries next clk; the live event goes out instead.
- Transitions:
  - SH_DN -> K_DN.
  - K_DN -> HOLD, counter=0.
  - K_UP -> SH_UP if shift latched, else GAP (counter=0).
  - SH_UP -> GAP, counter=0.
- HOLD/GAP timing:
  - Counter increments on tick.
  - HOLD exits to K_UP on the tick that makes the counter = HOLD_TICKS.
  - GAP exits to IDLE on the tick that makes the counter = GAP_TICKS.
  - A tick already high in the clk of entry is not counted.
- Abort:
  - at_abort in SH_DN: go to IDLE, nothing emitted.
  - at_abort in K_DN: go to SH_UP if shift latched, else GAP.
  - at_abort in HOLD: go to K_UP immediately. Release events are always emitted, so no key is left stuck down in the matrix.
  - at_abort in K_UP, SH_UP or GAP: ignored.
  - at_abort in IDLE: no effect.
- Back-to-back requests: at_valid held high re-triggers from IDLE the clk after GAP exits. Minimum per-key period is HOLD_TICKS+GAP_TICKS ticks.
- Live event for the same code as an in-flight auto key: passed through unchanged, with no suppression.
- Reset asserted mid-sequence:
  - Immediate return to IDLE with outputs 0; no release is emitted.
  - The downstream matrix is cleared by its own reset.
- out_strobe is never high for two sources in one clk; one event per clk maximum.

Test Plan:
- Live only: live_strobe, pressed=1, code 8'h1C at clk n -> out_strobe=1, out_code=8'h1C, out_pressed=1 at n+1 only; at_busy stays 0.
- Plain auto key: at_valid, code 8'h2D, shift=0, HOLD=3, GAP=2 -> press 8'h2D, release 8'h2D on the 3rd tick after press, at_ready=1 on the 2nd tick after release.
- Shifted key: code 8'h1E, shift=1 -> exact event order 12/1, 1E/1, 1E/0, 12/0 on consecutive non-stalled clks.
- Collision: live_strobe in the same clk as K_DN emission -> live event out first, then auto press 1 clk later; no event lost, no double strobe.
- Abort: at_abort mid-HOLD with shift=1 -> 1E/0 then 12/0 within 2 clks, then GAP, then IDLE.
- Reset mid-HOLD: assert reset asynchronously -> out_strobe=0 immediately, at_ready=1, at_busy=0. Next request starts clean from IDLE.

Source files
------------

// File: rtl/key_autotype_if.sv
// Key-event bus of the auto-type scheduler: frame tick, live PS/2 events,
// auto-type request channel and the merged event stream to the keyboard matrix.
interface key_autotype_if;
    logic       tick;
    logic       live_strobe;
    logic       live_pressed;
    logic [7:0] live_code;
    logic       at_valid;
    logic [7:0] at_code;
    logic       at_shift;
    logic       at_ready;
    logic       at_abort;
    logic       at_busy;
    logic       out_strobe;
    logic       out_pressed;
    logic [7:0] out_code;

    modport master (
        output tick, live_strobe, live_pressed, live_code,
        output at_valid, at_code, at_shift, at_abort,
        input  at_ready, at_busy, out_strobe, out_pressed, out_code
    );

    modport slave (
        input  tick, live_strobe, live_pressed, live_code,
        input  at_valid, at_code, at_shift, at_abort,
        output at_ready, at_busy, out_strobe, out_pressed, out_code
    );
endinterface

// File: rtl/key_autotype.sv
// Merges live key events with an auto-typed key stream onto one key-event port.
// Live events always win the port; auto-typed keys are held/gapped by frame ticks.
module key_autotype #(
    parameter int         HOLD_TICKS = 3,
    parameter int         GAP_TICKS  = 2,
    parameter logic [7:0] SHIFT_CODE = 8'h12
) (
    input logic           clk,
    input logic           reset,
    key_autotype_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SH_DN, S_K_DN, S_HOLD, S_K_UP, S_SH_UP, S_GAP
    } state_t;

    localparam logic [3:0] HOLD_N = 4'(HOLD_TICKS);
    localparam logic [3:0] GAP_N  = 4'(GAP_TICKS);

    state_t     state, state_nxt;
    logic [7:0] code_q;
    logic       shift_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_inc;

    logic       emit_vld_p0;
    logic       emit_pressed_p0;
    logic [7:0] emit_code_p0;

    logic       out_strobe_p1;
    logic       out_pressed_p1;
    logic [7:0] out_code_p1;

    assign cnt_inc = cnt_q + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Emit states only advance when the port was free; a live event forces a retry.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.at_valid) state_nxt = bus.at_shift ? S_SH_DN : S_K_DN;
            S_SH_DN: begin
                if (bus.at_abort)          state_nxt = S_IDLE;
                else if (!bus.live_strobe) state_nxt = S_K_DN;
            end
            S_K_DN: begin
                if (bus.at_abort)          state_nxt = shift_q ? S_SH_UP : S_GAP;
                else if (!bus.live_strobe) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (bus.at_abort)                      state_nxt = S_K_UP;
                else if (bus.tick && cnt_inc == HOLD_N) state_nxt = S_K_UP;
            end
            S_K_UP:  if (!bus.live_strobe) state_nxt = shift_q ? S_SH_UP : S_GAP;
            S_SH_UP: if (!bus.live_strobe) state_nxt = S_GAP;
            S_GAP:   if (bus.tick && cnt_inc == GAP_N) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        emit_vld_p0     = 1'b0;
        emit_pressed_p0 = 1'b0;
        emit_code_p0    = code_q;
        case (state)
            S_SH_DN: begin
                emit_vld_p0     = !bus.at_abort;
                emit_pressed_p0 = 1'b1;
                emit_code_p0    = SHIFT_CODE;
            end
            S_K_DN: begin
                emit_vld_p0     = !bus.at_abort;
                emit_pressed_p0 = 1'b1;
            end
            S_K_UP:  emit_vld_p0 = 1'b1;
            S_SH_UP: begin
                emit_vld_p0  = 1'b1;
                emit_code_p0 = SHIFT_CODE;
            end
            default: emit_vld_p0 = 1'b0;
        endcase
        if (bus.live_strobe) emit_vld_p0 = 1'b0;
        bus.at_ready = (state == S_IDLE);
        bus.at_busy  = (state != S_IDLE);
    end

    // Counter restarts on every state change, so a tick in the entry clk is never counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q  <= 8'd0;
            shift_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            if (state == S_IDLE && bus.at_valid) begin
                code_q  <= bus.at_code;
                shift_q <= bus.at_shift;
            end
            if (state_nxt != state)
                cnt_q <= 4'd0;
            else if (bus.tick && (state == S_HOLD || state == S_GAP))
                cnt_q <= cnt_inc;
        end
    end

    // p0 -> p1: single output register shared by both event sources
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_strobe_p1  <= 1'b0;
            out_pressed_p1 <= 1'b0;
            out_code_p1    <= 8'd0;
        end else if (bus.live_strobe) begin
            out_strobe_p1  <= 1'b1;
            out_pressed_p1 <= bus.live_pressed;
            out_code_p1    <= bus.live_code;
        end else if (emit_vld_p0) begin
            out_strobe_p1  <= 1'b1;
            out_pressed_p1 <= emit_pressed_p0;
            out_code_p1    <= emit_code_p0;
        end else begin
            out_strobe_p1  <= 1'b0;
        end
    end

    assign bus.out_strobe  = out_strobe_p1;
    assign bus.out_pressed = out_pressed_p1;
    assign bus.out_code    = out_code_p1;
endmodule
